// File: rtl/hue_ramp_gen.sv
// hue_ramp_gen: six-segment hue wheel walker feeding a three-channel PWM stage.
// A prescaler produces a step tick every GRAD_THRESH enabled cycles. Each tick
// advances a saturating ramp level. When the level tops out, the next tick moves
// to the next hue segment. Each channel's duty word is derived from the level
// and the segment.
// Optional build macro HUE_GAMMA_EN: squares each channel value, (v*v + MAX) >> R,
// before the output register. When undefined, linear values are registered and
// no multiplier is built.
module hue_ramp_gen #(
  parameter int R           = 8,
  parameter int GRAD_THRESH = 1000,
  parameter int STEP        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [R-1:0] duty_r,
  output logic [R-1:0] duty_g,
  output logic [R-1:0] duty_b,
  output logic [2:0]   seg,
  output logic         upd,
  output logic         wrap
);

  localparam logic [R-1:0] MAX      = {R{1'b1}};
  localparam logic [R-1:0] ZERO     = {R{1'b0}};
  localparam int           CW       = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GRAD_THRESH - 1);
  localparam logic [R:0]   STEP_W   = (R + 1)'(STEP);

  // Segment codes around the wheel; 6 and 7 are never entered legitimately.
  localparam logic [2:0] SEG_RY = 3'd0;  // red -> yellow
  localparam logic [2:0] SEG_YG = 3'd1;  // yellow -> green
  localparam logic [2:0] SEG_GC = 3'd2;  // green -> cyan
  localparam logic [2:0] SEG_CB = 3'd3;  // cyan -> blue
  localparam logic [2:0] SEG_BM = 3'd4;  // blue -> magenta
  localparam logic [2:0] SEG_MR = 3'd5;  // magenta -> red

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick;
  logic [R-1:0]       lvl_q, lvl_d;
  logic [R:0]         lvl_sum;
  logic [2:0]         seg_q, seg_d;
  logic               wrap_d;
  // Channel order inside the packed vectors: [2]=red, [1]=green, [0]=blue.
  logic [2:0][R-1:0]  lin_d;
  logic [2:0][R-1:0]  shaped_d;
  logic [2:0][R-1:0]  duty_q;
  logic               upd_q, wrap_q;

  // Step tick: last prescaler count while enabled.
  always_comb begin
    tick = en && (cnt_q == CNT_LAST);
  end

  // Prescaler next state: clear on tick, count while enabled, hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Segment/level state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_RY;
      lvl_q <= ZERO;
    end else begin
      seg_q <= seg_d;
      lvl_q <= lvl_d;
    end
  end

  // Segment/level next state. The level saturates at MAX and then wraps to 0
  // on the following tick, so the boundary colour is held for two ticks.
  always_comb begin
    lvl_sum = {1'b0, lvl_q} + STEP_W;
    lvl_d   = lvl_q;
    seg_d   = seg_q;
    wrap_d  = 1'b0;
    if (tick) begin
      if (seg_q > SEG_MR) begin
        // Recover from an illegal code back to the start of the wheel.
        seg_d = SEG_RY;
        lvl_d = ZERO;
      end else if (lvl_q == MAX) begin
        lvl_d = ZERO;
        if (seg_q == SEG_MR) begin
          seg_d  = SEG_RY;
          wrap_d = 1'b1;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end else begin
        // The sum carries out exactly when it exceeds MAX.
        lvl_d = lvl_sum[R] ? MAX : lvl_sum[R-1:0];
      end
    end
  end

  // Output decode: map the next segment and level to linear channel values.
  always_comb begin
    lin_d = {MAX, ZERO, ZERO};
    unique case (seg_d)
      SEG_RY:  lin_d = {MAX, lvl_d, ZERO};
      SEG_YG:  lin_d = {MAX - lvl_d, MAX, ZERO};
      SEG_GC:  lin_d = {ZERO, MAX, lvl_d};
      SEG_CB:  lin_d = {ZERO, MAX - lvl_d, MAX};
      SEG_BM:  lin_d = {lvl_d, ZERO, MAX};
      SEG_MR:  lin_d = {MAX, ZERO, MAX - lvl_d};
      default: lin_d = {MAX, ZERO, ZERO};
    endcase
  end

  // Per-channel shaping stage ahead of the output register.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
`ifdef HUE_GAMMA_EN
      logic [2*R-1:0] wide;
      logic [2*R-1:0] sq;
      assign wide = {{R{1'b0}}, lin_d[gi]};
      // The +MAX bias makes full scale map back to full scale.
      assign sq   = (wide * wide) + {{R{1'b0}}, MAX};
      assign shaped_d[gi] = sq[2*R-1:R];
`else
      assign shaped_d[gi] = lin_d[gi];
`endif
    end
  endgenerate

  // Output register: duty words reload only on a tick; pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= {MAX, ZERO, ZERO};
      upd_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (tick) begin
        duty_q <= shaped_d;
      end
      upd_q  <= tick;
      wrap_q <= wrap_d;
    end
  end

  assign duty_r = duty_q[2];
  assign duty_g = duty_q[1];
  assign duty_b = duty_q[0];
  assign seg    = seg_q;
  assign upd    = upd_q;
  assign wrap   = wrap_q;

endmodule

// File: doc/hue_ramp_gen.md
# hue_ramp_gen

Colour-sequence generator that sits directly upstream of the three-channel PWM stage. It walks a six-segment hue wheel (red → yellow → green → cyan → blue → magenta → red) and emits one R-bit duty word per colour channel. The PWM stage consumes these words unchanged. Step rate is set by a cycle prescaler, and an enable lets the sequence be frozen.

## Interface
- `R`, 8: duty word width; `MAX` = 2^R − 1.
- `GRAD_THRESH`, 1_000: clock cycles per ramp step (≥ 1).
- `STEP`, 1: level increment per ramp step (1 ≤ STEP ≤ MAX).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  advance enable; low freezes prescaler and outputs.
- `duty_r`  out  R  red duty word, registered.
- `duty_g`  out  R  green duty word, registered.
- `duty_b`  out  R  blue duty word, registered.
- `seg`  out  3  current segment 0–5, registered.
- `upd`  out  1  one-cycle pulse, duty words just reloaded.
- `wrap`  out  1  one-cycle pulse, segment 5 → 0 transition.

## Operation
- Internal state: prescaler `cnt` (0..GRAD_THRESH−1), ramp level `lvl` (R bits), segment `seg`.
- Tick condition: `en` high and `cnt == GRAD_THRESH−1`. When the tick fires, `cnt` clears to 0. Otherwise `cnt` increments while `en` is high and holds while `en` is low.
- Level update on tick:
  - If `lvl == MAX`: `lvl` ← 0 and `seg` advances (5 wraps to 0).
  - Otherwise: `lvl` ← min(`lvl`+`STEP`, MAX). This addition saturates; the sum is computed at R+1 bits.
- Channel mapping (U = `lvl`, D = MAX − `lvl`):
  - S0: r=MAX, g=U, b=0.
  - S1: r=D, g=MAX, b=0.
  - S2: r=0, g=MAX, b=U.
  - S3: r=0, g=D, b=MAX.
  - S4: r=U, g=0, b=MAX.
  - S5: r=MAX, g=0, b=D.
- Segment boundaries hold the same colour for two consecutive ticks; this is intended.
- Ticks per segment = ceil(MAX/STEP) + 1. With defaults this is 256 ticks per segment and 1536 ticks per full wheel.
- Duty words are reloaded and `upd` pulses on every tick, including boundary ticks.
- `wrap` pulses on the same cycle as `upd` when `seg` goes from 5 to 0.
- Segment codes 6 and 7 are unreachable. If either is decoded, the next tick forces `seg` to 0 and `lvl` to 0.

## Timing
- Reset state: `cnt`=0, `lvl`=0, `seg`=0, `duty_r`=MAX, `duty_g`=0, `duty_b`=0, `upd`=0, `wrap`=0.
- Latency: new duty/`seg` values, `upd` and `wrap` all appear on the edge after the tick cycle. Outputs then stay stable until the next tick.
- With `en` held high from reset release, the first `upd` occurs on the GRAD_THRESH-th rising edge after release.
- `en` deasserted on a tick cycle: no tick fires, and state is fully held.
- `rst` mid-sequence: reset state is taken on the next edge. `rst` overrides `en` and any pending tick.
- GRAD_THRESH = 1: a tick fires on every enabled cycle, so `upd` may stay high continuously.

## Configuration
- `HUE_GAMMA_EN`:
  - Defined: each channel value v is replaced by (v·v + MAX) >> R before the output register. The product is computed at 2R bits. This gives 0→0, MAX→MAX, 128→64 for R=8. Latency is unchanged.
  - Undefined: raw linear values are registered, with no multiplier in the netlist.

## Test plan
- Reset: R=8, GRAD_THRESH=4, STEP=1; hold `rst` high 2 cycles with `en`=1 → 255/0/0, `seg`=0, `upd`=0, `wrap`=0 throughout reset.
- First step: release `rst`, keep `en`=1 → first `upd` on the 4th edge after release, with `duty_g`=1. Next `upd` 4 cycles later, with `duty_g`=2.
- Segment boundary: after 256 ticks → `seg`=1, r=255, g=255. The 257th tick → r=254, g=255, b=0.
- Full wheel: after 1536 ticks → `wrap` and `upd` high for exactly one cycle, `seg`=0, outputs 255/0/0. `wrap` never pulses on any other tick.
- Freeze: drop `en` for 50 cycles mid-S2 → no `upd`, outputs and `seg` constant. When `en` is raised again, the next tick arrives after the remaining prescaler count, not a full GRAD_THRESH.
- Saturation/gamma: STEP=100 → `duty_g` sequence in S0 is 0, 100, 200, 255, then `seg`=1. With `HUE_GAMMA_EN` and STEP=1, at `lvl`=128 in S0 → `duty_g`=64 and `duty_r`=255.
